// File: rtl/bitstream_loader_if.sv
// Word stream feeding the bitstream loader: a plain valid/ready handshake.
// The master drives data and valid, the loader (slave) answers with ready.
interface bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bitstream_loader.sv
// Serialises a word stream into a configuration chain, LSB first, two clk cycles per bit,
// while packing the bits falling out of the chain tail into readback words.
module bitstream_loader #(
    parameter int CHAIN_LEN = 136,
    parameter int WORD_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    bitstream_loader_if.slave   s_if,
    output logic                prog_clk,
    output logic                prog_en,
    output logic                prog_in,
    input  logic                prog_out,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_valid,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_W - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] SHIFT_LO = 3'd2;
    localparam logic [2:0] SHIFT_HI = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] rb_sh_q, rb_sh_d;
    logic [WORD_W-1:0] rb_word;
    logic [WORD_W-1:0] rb_data_d;
    logic              rb_valid_d;
    logic              prog_en_d;
    logic              prog_clk_d;
    logic              prog_in_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_d;
    logic              done_d;

    // Every output is a register, so its next value is derived from the next state.
    // The current word is shifted right between bits, keeping the active bit at word[0].
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        word_d     = word_q;
        rb_sh_d    = rb_sh_q;
        rb_word    = rb_sh_q;
        rb_data_d  = rb_data;
        rb_valid_d = 1'b0;
        prog_en_d  = prog_en;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = '0;
                    rb_sh_d   = '0;
                    prog_en_d = 1'b1;
                end
            end
            FETCH: begin
                if (s_if.s_valid && s_ready_q) begin
                    word_d    = s_if.s_data;
                    bit_idx_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // The tail bit is taken before prog_clk rises, so it is still the old chain content.
                rb_word[bit_idx_q] = prog_out;
                if (bit_idx_q == IDX_LAST || bit_cnt_q == LAST_BIT) begin
                    rb_data_d  = rb_word;
                    rb_valid_d = 1'b1;
                    rb_sh_d    = '0;
                end else begin
                    rb_sh_d = rb_word;
                end
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_d == CHAIN_END) begin
                    state_d   = DONE;
                    prog_en_d = 1'b0;
                end else if (bit_idx_q == IDX_LAST) begin
                    state_d = FETCH;
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    word_d    = word_q >> 1;
                    state_d   = SHIFT_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d  = (state_d == FETCH);
        busy_d     = (state_d == FETCH) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
        done_d     = (state_d == DONE);
        prog_clk_d = (state_d == SHIFT_HI);
        prog_in_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? word_d[0] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            word_q    <= '0;
            rb_sh_q   <= '0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
            prog_en   <= 1'b0;
            prog_clk  <= 1'b0;
            prog_in   <= 1'b0;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            word_q    <= word_d;
            rb_sh_q   <= rb_sh_d;
            rb_data   <= rb_data_d;
            rb_valid  <= rb_valid_d;
            prog_en   <= prog_en_d;
            prog_clk  <= prog_clk_d;
            prog_in   <= prog_in_d;
            s_ready_q <= s_ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign s_if.s_ready = s_ready_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: a 16-bit and a 10-bit chain instance, each with a
// behavioural shift-register chain model hanging off prog_clk/prog_in/prog_out.
module tb_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start16, start10;

    bitstream_loader_if #(.WORD_W(8)) if16 ();
    bitstream_loader_if #(.WORD_W(8)) if10 ();

    logic       p16_clk, p16_en, p16_in, rb16_valid, busy16, done16;
    logic [7:0] rb16_data;
    logic       p10_clk, p10_en, p10_in, rb10_valid, busy10, done10;
    logic [7:0] rb10_data;

    logic [15:0] chain16;
    logic [9:0]  chain10;

    int          checks = 0;
    int          errors = 0;

    int          pclk16, pclk10, rbn16, rbn10, xfer16, xfer10;
    logic [31:0] pin_seq16, pin_seq10;
    logic [7:0]  rb_log16 [4];
    logic [7:0]  rb_log10 [4];

    bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start16),
        .s_if     (if16),
        .prog_clk (p16_clk),
        .prog_en  (p16_en),
        .prog_in  (p16_in),
        .prog_out (chain16[0]),
        .rb_data  (rb16_data),
        .rb_valid (rb16_valid),
        .busy     (busy16),
        .done     (done16)
    );

    bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start10),
        .s_if     (if10),
        .prog_clk (p10_clk),
        .prog_en  (p10_en),
        .prog_in  (p10_in),
        .prog_out (chain10[0]),
        .rb_data  (rb10_data),
        .rb_valid (rb10_valid),
        .busy     (busy10),
        .done     (done10)
    );

    // Chain models: shift toward bit 0 on each prog_clk rise, bit 0 is the tail.
    always @(posedge p16_clk) begin
        if (pclk16 < 32) pin_seq16[pclk16[4:0]] = p16_in;
        pclk16 = pclk16 + 1;
        chain16 = {p16_in, chain16[15:1]};
    end

    always @(posedge p10_clk) begin
        if (pclk10 < 32) pin_seq10[pclk10[4:0]] = p10_in;
        pclk10 = pclk10 + 1;
        chain10 = {p10_in, chain10[9:1]};
    end

    always @(posedge clk) begin
        if (rb16_valid) begin
            if (rbn16 < 4) rb_log16[rbn16[1:0]] = rb16_data;
            rbn16 = rbn16 + 1;
        end
        if (rb10_valid) begin
            if (rbn10 < 4) rb_log10[rbn10[1:0]] = rb10_data;
            rbn10 = rbn10 + 1;
        end
        if (if16.s_valid && if16.s_ready) xfer16 = xfer16 + 1;
        if (if10.s_valid && if10.s_ready) xfer10 = xfer10 + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetLogs();
        pclk16 = 0; pclk10 = 0; rbn16 = 0; rbn10 = 0; xfer16 = 0; xfer10 = 0;
        pin_seq16 = '0; pin_seq10 = '0;
        for (int i = 0; i < 4; i++) begin
            rb_log16[i] = '0;
            rb_log10[i] = '0;
        end
    endtask

    task automatic pulseStart(input bit sel);
        @(negedge clk);
        if (sel) start10 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        start16 = 1'b0;
    endtask

    // Waits for FETCH, optionally holds s_valid low for a number of cycles, then transfers one word.
    task automatic applyStimulus(input bit sel, input logic [7:0] w, input int stall);
        int n = 0;
        while (!(sel ? if10.s_ready : if16.s_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fetch_wait_bound", 32'(n < 100), 32'd1);
        for (int i = 0; i < stall; i++) begin
            checkOutput("stall_prog_clk", 32'(sel ? p10_clk : p16_clk), 32'd0);
            checkOutput("stall_prog_en", 32'(sel ? p10_en : p16_en), 32'd1);
            @(negedge clk);
        end
        if (stall > 0) checkOutput("stall_ready", 32'(sel ? if10.s_ready : if16.s_ready), 32'd1);
        if (sel) begin
            if10.s_data  = w;
            if10.s_valid = 1'b1;
        end else begin
            if16.s_data  = w;
            if16.s_valid = 1'b1;
        end
        @(negedge clk);
        if10.s_valid = 1'b0;
        if16.s_valid = 1'b0;
    endtask

    task automatic waitDone(input bit sel);
        int n = 0;
        while (!(sel ? done10 : done16) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_bound", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start16 = 1'b0;
        start10 = 1'b0;
        if16.s_valid = 1'b0;
        if16.s_data  = '0;
        if10.s_valid = 1'b0;
        if10.s_data  = '0;
        chain16 = '0;
        chain10 = '0;
        resetLogs();
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy16), 32'd0);
        checkOutput("rst_done", 32'(done16), 32'd0);
        checkOutput("rst_prog_en", 32'(p16_en), 32'd0);
        checkOutput("rst_prog_clk", 32'(p16_clk), 32'd0);
        checkOutput("rst_prog_in", 32'(p16_in), 32'd0);
        checkOutput("rst_s_ready", 32'(if16.s_ready), 32'd0);
        checkOutput("rst_rb_valid", 32'(rb16_valid), 32'd0);
        checkOutput("rst_rb_data", 32'(rb16_data), 32'd0);
        rst_n = 1'b1;

        $display("[TB] basic load with readback");
        chain16 = 16'hF00F;
        resetLogs();
        pulseStart(1'b0);
        checkOutput("start_busy", 32'(busy16), 32'd1);
        checkOutput("start_prog_en", 32'(p16_en), 32'd1);
        checkOutput("start_s_ready", 32'(if16.s_ready), 32'd1);
        applyStimulus(1'b0, 8'hA5, 0);
        checkOutput("shift_s_ready", 32'(if16.s_ready), 32'd0);
        applyStimulus(1'b0, 8'h3C, 0);
        waitDone(1'b0);
        checkOutput("basic_pulses", 32'(pclk16), 32'd16);
        checkOutput("basic_prog_in_seq", {16'h0, pin_seq16[15:0]}, 32'h3CA5);
        checkOutput("basic_chain", {16'h0, chain16}, 32'h3CA5);
        checkOutput("basic_transfers", 32'(xfer16), 32'd2);
        checkOutput("basic_rb_count", 32'(rbn16), 32'd2);
        checkOutput("basic_rb0", 32'(rb_log16[0]), 32'h0F);
        checkOutput("basic_rb1", 32'(rb_log16[1]), 32'hF0);
        checkOutput("done_prog_en", 32'(p16_en), 32'd0);
        checkOutput("done_busy", 32'(busy16), 32'd0);
        checkOutput("done_prog_clk", 32'(p16_clk), 32'd0);
        checkOutput("done_prog_in", 32'(p16_in), 32'd0);

        $display("[TB] back-to-back load with stall and ignored start");
        resetLogs();
        pulseStart(1'b0);
        checkOutput("b2b_done_drop", 32'(done16), 32'd0);
        checkOutput("b2b_prog_en", 32'(p16_en), 32'd1);
        applyStimulus(1'b0, 8'h12, 0);
        repeat (2) @(negedge clk);
        pulseStart(1'b0);
        checkOutput("ignored_start_ready", 32'(if16.s_ready), 32'd0);
        checkOutput("ignored_start_busy", 32'(busy16), 32'd1);
        applyStimulus(1'b0, 8'h34, 5);
        waitDone(1'b0);
        checkOutput("b2b_pulses", 32'(pclk16), 32'd16);
        checkOutput("b2b_chain", {16'h0, chain16}, 32'h3412);
        checkOutput("b2b_transfers", 32'(xfer16), 32'd2);
        checkOutput("b2b_rb0", 32'(rb_log16[0]), 32'hA5);
        checkOutput("b2b_rb1", 32'(rb_log16[1]), 32'h3C);

        $display("[TB] reset mid-load");
        resetLogs();
        pulseStart(1'b0);
        applyStimulus(1'b0, 8'hFF, 0);
        n = 0;
        while (pclk16 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_bit5_bound", 32'(n < 200), 32'd1);
        rst_n = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_prog_en", 32'(p16_en), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy16), 32'd0);
        checkOutput("mid_rst_s_ready", 32'(if16.s_ready), 32'd0);
        checkOutput("mid_rst_prog_clk", 32'(p16_clk), 32'd0);
        rst_n = 1'b1;
        start16 = 1'b0;
        resetLogs();
        pulseStart(1'b0);
        applyStimulus(1'b0, 8'h5A, 0);
        applyStimulus(1'b0, 8'hC3, 0);
        waitDone(1'b0);
        checkOutput("reload_pulses", 32'(pclk16), 32'd16);
        checkOutput("reload_prog_in_seq", {16'h0, pin_seq16[15:0]}, 32'hC35A);
        checkOutput("reload_chain", {16'h0, chain16}, 32'hC35A);
        checkOutput("reload_transfers", 32'(xfer16), 32'd2);

        $display("[TB] partial final word");
        chain10 = 10'h2C3;
        resetLogs();
        pulseStart(1'b1);
        applyStimulus(1'b1, 8'h96, 0);
        applyStimulus(1'b1, 8'hFD, 0);
        waitDone(1'b1);
        checkOutput("part_pulses", 32'(pclk10), 32'd10);
        checkOutput("part_prog_in_seq", {22'h0, pin_seq10[9:0]}, 32'h196);
        checkOutput("part_chain", {22'h0, chain10}, 32'h196);
        checkOutput("part_rb_count", 32'(rbn10), 32'd2);
        checkOutput("part_rb0", 32'(rb_log10[0]), 32'hC3);
        checkOutput("part_rb1", 32'(rb_log10[1]), 32'h02);
        if10.s_data  = 8'h77;
        if10.s_valid = 1'b1;
        repeat (3) @(negedge clk);
        if10.s_valid = 1'b0;
        checkOutput("part_transfers", 32'(xfer10), 32'd2);
        checkOutput("part_done_ready", 32'(if10.s_ready), 32'd0);
        checkOutput("part_done", 32'(done10), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 136: total number of configuration bits in the target programming chain.
REQ-002 Parameter WORD_W, default 8: width of each bitstream word and each readback word.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 s_data  input  WORD_W  bitstream word; LSB is shifted first.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  loader accepts s_data; a transfer occurs when s_valid and s_ready are both high on a clk edge.
REQ-009 prog_clk  output  1  programming chain clock; the chain samples prog_in on its rising edge.
REQ-010 prog_en  output  1  programming chain enable.
REQ-011 prog_in  output  1  serial configuration bit to the chain.
REQ-012 prog_out  input  1  serial output from the chain tail, used for readback.
REQ-013 rb_data  output  WORD_W  packed readback word (previous chain contents), LSB = first bit out.
REQ-014 rb_valid  output  1  one-cycle pulse qualifying rb_data; there is no backpressure.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  high in DONE until the next start or reset.

Function
REQ-017 States SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI and DONE, all registered.
REQ-018 IDLE/DONE: start goes to FETCH, clears the bit counter and sets prog_en=1; done drops on the same edge.
REQ-019 FETCH: s_ready=1; on a transfer, latch s_data into the shift word, set the word bit index to 0 and go to SHIFT_LO.
REQ-020 s_ready SHALL be 0 in every state except FETCH, so at most one word is accepted per fetch.
REQ-021 SHIFT_LO (one cycle): prog_clk=0 and prog_in=current word bit.
REQ-022 On exit from SHIFT_LO, sample prog_out into the readback shift register, then go to SHIFT_HI.
REQ-023 SHIFT_HI (one cycle): prog_clk=1 and prog_in is held; the bit counter increments on exit.
REQ-024 SHIFT_HI exit: if the bit counter reaches CHAIN_LEN, go to DONE.
REQ-025 SHIFT_HI exit: otherwise, if the word bit index equals WORD_W-1, go to FETCH.
REQ-026 SHIFT_HI exit: otherwise increment the word bit index and go to SHIFT_LO.
REQ-027 Each configuration bit SHALL take exactly 2 clk cycles; no FETCH cycles occur mid-word.
REQ-028 Words consumed per load SHALL equal ceil(CHAIN_LEN/WORD_W); unused upper bits of the final word are discarded.
REQ-029 rb_valid SHALL pulse the cycle after the sample completing WORD_W readback bits or completing bit CHAIN_LEN.
REQ-030 A partial final readback word SHALL be zero-filled in its upper bits.
REQ-031 The bit counter SHALL be clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-032 prog_en SHALL stay 1 from the start edge until the DONE entry edge, then return to 0; prog_clk and prog_in SHALL be 0 outside SHIFT states.
REQ-033 start asserted while busy SHALL be ignored, with no restart and no state change.
REQ-034 s_valid low in FETCH SHALL stall indefinitely with prog_clk=0 and prog_en=1; no timeout.
REQ-035 All outputs SHALL be driven directly from registers.

Reset
REQ-036 rst_n=0 on a clk edge SHALL force IDLE and zero every output, the counters and the readback register.
REQ-037 Reset SHALL take priority over start and over any transfer on the same edge.
REQ-038 Reset mid-load SHALL abandon the load; the next load restarts from bit 0.

Verification
REQ-039 Basic load: CHAIN_LEN=16, WORD_W=8, start then words 0xA5, 0x3C -> prog_in sequence on prog_clk rising edges is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done after 16 prog_clk pulses; exactly 2 transfers.
REQ-040 Readback: chain preloaded with 0xF00F (first-out 0x0F) -> rb_valid pulses twice with rb_data 0x0F then 0xF0.
REQ-041 Partial word: CHAIN_LEN=10 -> 2 words accepted; only bits 0-1 of word 2 are shifted; second rb_data has bits 7:2 = 0.
REQ-042 Stall and ignored start: s_valid low for 5 cycles in FETCH, with start pulsed during SHIFT -> prog_clk stays 0 for the stall, no restart occurs, and the total shift count is unchanged.
REQ-043 Reset mid-load: rst_n=0 after bit 5 -> next cycle prog_en=0, busy=0 and s_ready=0; a new start loads a full CHAIN_LEN bits.
REQ-044 Back-to-back loads: start in DONE -> done drops on the same edge, prog_en=1, and a second full load completes correctly.
